// File: rtl/fog_cfg_sequencer.sv
// FOG loop run-time parameter bank: shadow writes, atomic commit on modulation sync, settle window.
// Optional FOG_CFG_FB_GATE_EN: hold fb_ON at 0 through settle when freq/amplitude parameters change.
module fog_cfg_sequencer #(
    parameter logic        [31:0] DEF_FREQ_CNT = 32'd100,
    parameter logic        [31:0] DEF_AMP_H    = 32'd8192,
    parameter logic signed [31:0] DEF_AMP_L    = -32'sd8192,
    parameter logic        [31:0] DEF_WAIT_CNT = 32'd20,
    parameter int unsigned        SETTLE_SYNCS = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_wr_valid,
    output logic        o_wr_ready,
    input  logic [3:0]  i_wr_addr,
    input  logic [31:0] i_wr_data,
    output logic        o_wr_err,
    input  logic        i_commit,
    input  logic        i_sync,
    input  logic [31:0] i_timeout_cnt,
    output logic [31:0] o_freq_cnt,
    output logic [31:0] o_amp_H,
    output logic [31:0] o_amp_L,
    output logic [31:0] o_wait_cnt,
    output logic [31:0] o_err_offset,
    output logic [31:0] o_avg_sel,
    output logic [31:0] o_const_step,
    output logic [31:0] o_fb_ON,
    output logic [31:0] o_gainSel_step,
    output logic [31:0] o_gainSel_ramp,
    output logic        o_polarity,
    output logic        o_busy,
    output logic        o_commit_done,
    output logic        o_timeout
);
    localparam int unsigned DW     = 32;
    localparam int unsigned NPAR   = 10;
    localparam int unsigned IW     = 4;
    localparam int unsigned SW     = 8;
    localparam int unsigned FB_IDX = 7;

    typedef enum logic [1:0] {S_IDLE, S_ARM, S_COMMIT, S_SETTLE} state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  sh_q  [NPAR];
    logic [DW-1:0]  act_q [NPAR];
    logic           sh_pol_q, act_pol_q;
    logic [DW-1:0]  tmo_cnt_q, tmo_inc;
    logic [SW-1:0]  settle_q, settle_inc;
    logic           wr_ready_q, wr_err_q, busy_q, done_q, timeout_q;
    logic           wr_fire, wr_hit, wr_pol;
    logic [IW-1:0]  wr_idx;
    logic           load, tmo_hit, done;

    // Bank index for parameters 0..9; polarity (addr 3) is held separately as a single bit.
    function automatic logic [DW-1:0] def_val(input int unsigned idx);
        case (idx)
            0:       def_val = DEF_FREQ_CNT;
            1:       def_val = DEF_AMP_H;
            2:       def_val = DW'(DEF_AMP_L);
            3:       def_val = DEF_WAIT_CNT;
            default: def_val = '0;
        endcase
    endfunction

    assign wr_fire    = i_wr_valid & wr_ready_q;
    assign tmo_inc    = (tmo_cnt_q == '1) ? tmo_cnt_q : tmo_cnt_q + DW'(1);
    assign settle_inc = settle_q + SW'(1);

    always_comb begin
        wr_hit = 1'b1;
        wr_pol = 1'b0;
        wr_idx = '0;
        case (i_wr_addr)
            4'd0, 4'd1, 4'd2: wr_idx = i_wr_addr;
            4'd3:             wr_pol = 1'b1;
            4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10: wr_idx = i_wr_addr - IW'(1);
            default:          wr_hit = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        tmo_hit = 1'b0;
        done    = 1'b0;
        case (state_q)
            S_IDLE: if (i_commit) state_d = S_ARM;
            S_ARM: begin
                if (i_sync) begin
                    state_d = S_COMMIT;
                    load    = 1'b1;
                end else if (i_timeout_cnt != '0 && tmo_inc >= i_timeout_cnt) begin
                    state_d = S_IDLE;
                    tmo_hit = 1'b1;
                end
            end
            S_COMMIT: state_d = S_SETTLE;
            S_SETTLE: begin
                if (i_sync && settle_inc == SW'(SETTLE_SYNCS)) begin
                    state_d = S_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control counters and status pulses.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tmo_cnt_q  <= '0;
            settle_q   <= '0;
            wr_ready_q <= 1'b1;
            wr_err_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == S_ARM) tmo_cnt_q <= tmo_inc;
            else                  tmo_cnt_q <= '0;
            if (state_q == S_COMMIT)                settle_q <= '0;
            else if (state_q == S_SETTLE && i_sync) settle_q <= settle_inc;
            wr_ready_q <= (state_d == S_IDLE);
            wr_err_q   <= wr_fire & ~wr_hit;
            busy_q     <= (state_d != S_IDLE);
            done_q     <= done;
            timeout_q  <= tmo_hit;
        end
    end

    // Shadow takes CPU writes; active bank copies the whole shadow at once.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned i = 0; i < NPAR; i++) begin
                sh_q[i]  <= def_val(i);
                act_q[i] <= def_val(i);
            end
            sh_pol_q  <= 1'b0;
            act_pol_q <= 1'b0;
        end else begin
            if (wr_fire && wr_hit) begin
                if (wr_pol) sh_pol_q     <= i_wr_data[0];
                else        sh_q[wr_idx] <= i_wr_data;
            end
            if (load) begin
                for (int unsigned i = 0; i < NPAR; i++) act_q[i] <= sh_q[i];
                act_pol_q <= sh_pol_q;
            end
        end
    end

`ifdef FOG_CFG_FB_GATE_EN
    logic [DW-1:0] fb_q;
    logic          loop_change;

    assign loop_change = (sh_q[0] != act_q[0]) | (sh_q[1] != act_q[1]) | (sh_q[2] != act_q[2]);

    // Feedback held off while the loop re-settles after a frequency or amplitude change.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)     fb_q <= '0;
        else if (load) fb_q <= loop_change ? '0 : sh_q[FB_IDX];
        else if (done) fb_q <= act_q[FB_IDX];
    end

    assign o_fb_ON = fb_q;
`else
    assign o_fb_ON = act_q[FB_IDX];
`endif

    assign o_wr_ready     = wr_ready_q;
    assign o_wr_err       = wr_err_q;
    assign o_busy         = busy_q;
    assign o_commit_done  = done_q;
    assign o_timeout      = timeout_q;
    assign o_polarity     = act_pol_q;
    assign o_freq_cnt     = act_q[0];
    assign o_amp_H        = act_q[1];
    assign o_amp_L        = act_q[2];
    assign o_wait_cnt     = act_q[3];
    assign o_err_offset   = act_q[4];
    assign o_avg_sel      = act_q[5];
    assign o_const_step   = act_q[6];
    assign o_gainSel_step = act_q[8];
    assign o_gainSel_ramp = act_q[9];
endmodule
